// File: rtl/lambda_scheduler.sv
// Time-multiplexes one lambda layer over an N_LATENT-element latent vector: load, settle/capture per element, stream out.
// Optional cycle_count performance port is enabled by defining LAMBDA_SCHED_PERF_EN.
module lambda_scheduler #(
    parameter int DW       = 16,
    parameter int N_LATENT = 4,
    parameter int LAT      = 8,
    parameter int IW       = (N_LATENT > 1) ? $clog2(N_LATENT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_mean,
    input  logic [DW-1:0] in_var,
    output logic          lam_reset,
    output logic [DW-1:0] lam_mean,
    output logic [DW-1:0] lam_var,
    input  logic [DW-1:0] lam_out,
    output logic          z_valid,
    input  logic          z_ready,
    output logic [DW-1:0] z_data,
    output logic [IW-1:0] z_index,
    output logic          busy,
    output logic          done
`ifdef LAMBDA_SCHED_PERF_EN
    ,
    output logic [15:0]   cycle_count
`endif
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_LATENT - 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        state_q;
    logic [IW-1:0] k_q, j_q;
    logic [IW-1:0] k_inc, j_inc;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] mean_buf_q [N_LATENT];
    logic [DW-1:0] var_buf_q  [N_LATENT];
    logic [DW-1:0] res_q      [N_LATENT];
    logic          lam_reset_q, in_ready_q, z_valid_q, busy_q, done_q;
    logic [DW-1:0] lam_mean_q, lam_var_q, z_data_q;
    logic [IW-1:0] z_index_q;
`ifdef LAMBDA_SCHED_PERF_EN
    logic [15:0]   cycle_q;
`endif

    always_comb begin
        k_inc = k_q + IW'(1);
        j_inc = j_q + IW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            cnt_q       <= '0;
            lam_reset_q <= 1'b1;
            lam_mean_q  <= '0;
            lam_var_q   <= '0;
            in_ready_q  <= 1'b0;
            z_valid_q   <= 1'b0;
            z_data_q    <= '0;
            z_index_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the buffers are small register files, so they are cleared with everything else rather than left undefined.
            for (int i = 0; i < N_LATENT; i++) begin
                mean_buf_q[i] <= '0;
                var_buf_q[i]  <= '0;
                res_q[i]      <= '0;
            end
`ifdef LAMBDA_SCHED_PERF_EN
            cycle_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Buffer contents survive an abort but are never re-used without a fresh load.
                state_q     <= S_IDLE;
                lam_reset_q <= 1'b1;
                in_ready_q  <= 1'b0;
                z_valid_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
`ifdef LAMBDA_SCHED_PERF_EN
                if (busy_q && cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
`endif
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_LOAD;
                            k_q        <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
`ifdef LAMBDA_SCHED_PERF_EN
                            cycle_q    <= 16'd1;  // the accepting IDLE cycle counts
`endif
                        end
                    end
                    S_LOAD: begin
                        if (in_valid && in_ready_q) begin
                            mean_buf_q[k_q] <= in_mean;
                            var_buf_q[k_q]  <= in_var;
                            if (k_q == LAST_IDX) begin
                                state_q    <= S_RST;
                                k_q        <= '0;
                                in_ready_q <= 1'b0;
                                lam_mean_q <= (N_LATENT == 1) ? in_mean : mean_buf_q[0];
                                lam_var_q  <= (N_LATENT == 1) ? in_var  : var_buf_q[0];
                            end else begin
                                k_q <= k_inc;
                            end
                        end
                    end
                    S_RST: begin
                        state_q     <= S_WAIT;
                        cnt_q       <= WAIT_INIT;
                        lam_reset_q <= 1'b0;
                    end
                    S_WAIT: begin
                        if (cnt_q == '0) begin
                            res_q[k_q]  <= lam_out;
                            lam_reset_q <= 1'b1;
                            if (k_q == LAST_IDX) begin
                                state_q   <= S_OUT;
                                j_q       <= '0;
                                z_valid_q <= 1'b1;
                                z_index_q <= '0;
                                z_data_q  <= (N_LATENT == 1) ? lam_out : res_q[0];
                            end else begin
                                state_q    <= S_RST;
                                k_q        <= k_inc;
                                lam_mean_q <= mean_buf_q[k_inc];
                                lam_var_q  <= var_buf_q[k_inc];
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_OUT: begin
                        if (z_ready) begin
                            if (j_q == LAST_IDX) begin
                                state_q   <= S_IDLE;
                                z_valid_q <= 1'b0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                j_q       <= j_inc;
                                z_index_q <= j_inc;
                                z_data_q  <= res_q[j_inc];
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign lam_reset = lam_reset_q;
    assign lam_mean  = lam_mean_q;
    assign lam_var   = lam_var_q;
    assign z_valid   = z_valid_q;
    assign z_data    = z_data_q;
    assign z_index   = z_index_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef LAMBDA_SCHED_PERF_EN
    assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_lambda_scheduler.sv
// Self-checking bench for lambda_scheduler: directed scenarios plus randomized vectors against a sum-based reference model.
`timescale 1ns/1ps
module tb_lambda_scheduler;

    localparam int DW      = 16;
    localparam int N       = 4;
    localparam int LAT     = 8;
    localparam int IW      = 2;
    localparam int COMPUTE = N * (1 + LAT);
    localparam int NO_GAP  = N;

    logic          clk = 1'b0;
    logic          reset, start, abort, in_valid, in_ready;
    logic [DW-1:0] in_mean, in_var, lam_mean, lam_var, lam_out, z_data;
    logic          lam_reset, z_valid, z_ready, busy, done;
    logic [IW-1:0] z_index;
`ifdef LAMBDA_SCHED_PERF_EN
    logic [15:0]   cycle_count;
    logic [15:0]   frozen_cc;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_a [N];
    logic [DW-1:0] v_a [N];
    logic [DW-1:0] exp_z [N];

    always #5 clk = ~clk;

    lambda_scheduler #(.DW(DW), .N_LATENT(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_mean(in_mean), .in_var(in_var),
        .lam_reset(lam_reset), .lam_mean(lam_mean), .lam_var(lam_var), .lam_out(lam_out),
        .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data), .z_index(z_index),
        .busy(busy), .done(done)
`ifdef LAMBDA_SCHED_PERF_EN
        , .cycle_count(cycle_count)
`endif
    );

    // Lambda layer stub: 0 while in reset, mean+var from two cycles after reset falls.
    logic [1:0]    since_q;
    logic [DW-1:0] stub_q;
    always @(posedge clk) begin
        if (lam_reset) begin
            since_q <= 2'd0;
            stub_q  <= '0;
        end else begin
            if (since_q != 2'd3) since_q <= since_q + 2'd1;
            stub_q <= (since_q >= 2'd1) ? DW'(lam_mean + lam_var) : '0;
        end
    end
    assign lam_out = lam_reset ? '0 : stub_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model();
        for (int i = 0; i < N; i++) exp_z[i] = m_a[i] + v_a[i];
    endtask

    task automatic gen_vector();
        for (int i = 0; i < N; i++) begin
            m_a[i] = 16'($urandom);
            v_a[i] = 16'($urandom);
        end
        set_model();
    endtask

    task automatic load_vector(input int gap_idx, input int gap_len);
        for (int i = 0; i < N; i++) begin
            if (i == gap_idx) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    in_mean  = 16'($urandom);
                    in_var   = 16'($urandom);
                    tick();
                    check("gap_in_ready", in_ready, 1);
                    check("gap_lam_reset", lam_reset, 1);
                end
            end
            check("load_in_ready", in_ready, 1);
            check("load_lam_reset", lam_reset, 1);
            in_valid = 1'b1;
            in_mean  = m_a[i];
            in_var   = v_a[i];
            tick();
        end
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_lam_reset", lam_reset, 1);
        check("rst_lam_mean", lam_mean, m_a[0]);
        check("rst_lam_var", lam_var, v_a[0]);
    endtask

    task automatic compute(input bit noise);
        int lat = 0;
        int low = 0;
        while (!z_valid && lat < 500) begin
            if (noise && lat == 5) begin
                start    = 1'b1;
                in_valid = 1'b1;
                in_mean  = 16'($urandom);
                in_var   = 16'($urandom);
            end else if (noise && lat == 7) begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            if (!lam_reset) low++;
            tick();
            lat++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("compute_latency", lat, COMPUTE);
        check("lam_reset_low_cycles", low, N * LAT);
    endtask

    task automatic drain(input int mode, input int perf_exp);
        int            j = 0;
        int            cyc = 0;
        bit            hold = 1'b0;
        bit            zr;
        logic [DW-1:0] hd;
        logic [IW-1:0] hi;
        while (j < N && cyc < 400) begin
            if (hold) begin
                check("hold_data", z_data, hd);
                check("hold_index", z_index, hi);
            end
            check("out_valid", z_valid, 1);
            check("no_early_done", done, 0);
            zr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            z_ready = zr;
            if (zr) begin
                check("z_data", z_data, exp_z[j]);
                check("z_index", z_index, j);
                j++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                hd   = z_data;
                hi   = z_index;
            end
            tick();
            cyc++;
        end
        z_ready = 1'b0;
        check("drain_count", j, N);
        check("done_pulse", done, 1);
        check("z_valid_after_done", z_valid, 0);
        check("busy_after_done", busy, 0);
`ifdef LAMBDA_SCHED_PERF_EN
        if (perf_exp >= 0) check("cycle_count", cycle_count, perf_exp);
        frozen_cc = cycle_count;
`endif
        tick();
        check("done_one_cycle", done, 0);
        tick();
`ifdef LAMBDA_SCHED_PERF_EN
        check("cycle_count_frozen", cycle_count, frozen_cc);
`endif
    endtask

    task automatic run_vector(input int gap_idx, input int gap_len, input bit noise,
                              input int mode, input int perf_exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        load_vector(gap_idx, gap_len);
        compute(noise);
        drain(mode, perf_exp);
    endtask

    initial begin
        bit seen_valid, seen_done, seen_busy;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_mean = '0; in_var = '0; z_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lam_reset", lam_reset, 1);
        check("reset_z_valid", z_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_done", done, 0);
        check("reset_z_data", z_data, 0);
        check("reset_z_index", z_index, 0);
        check("reset_lam_mean", lam_mean, 0);
`ifdef LAMBDA_SCHED_PERF_EN
        check("reset_cycle_count", cycle_count, 0);
`endif
        reset = 1'b1;
        tick();

        // Nominal run
        m_a = '{16'h0010, 16'h0100, 16'hFFFF, 16'h0000};
        v_a = '{16'h0001, 16'h0002, 16'h0002, 16'h0000};
        set_model();
        run_vector(NO_GAP, 0, 1'b0, 0, 1 + N + COMPUTE + N);

        // Backpressure 1,0,0,1,...
        run_vector(NO_GAP, 0, 1'b0, 1, -1);

        // Gapped input between pairs 1 and 2
        run_vector(1, 5, 1'b0, 0, 1 + N + 5 + COMPUTE + N);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_in_ready", in_ready, 0);

        // Abort in WAIT of element 2
        gen_vector();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_vector(NO_GAP, 0);
        repeat (21) tick();
        check("pre_abort_in_wait", lam_reset, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_lam_reset", lam_reset, 1);
        check("abort_busy", busy, 0);
        check("abort_z_valid", z_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", done, 0);
`ifdef LAMBDA_SCHED_PERF_EN
        frozen_cc = cycle_count;
`endif
        seen_valid = 1'b0; seen_done = 1'b0; seen_busy = 1'b0;
        z_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            seen_valid |= z_valid;
            seen_done  |= done;
            seen_busy  |= busy;
        end
        z_ready = 1'b0;
        check("abort_no_z_valid", seen_valid, 0);
        check("abort_no_done", seen_done, 0);
        check("abort_stays_idle", seen_busy, 0);
`ifdef LAMBDA_SCHED_PERF_EN
        check("abort_cycle_count_frozen", cycle_count, frozen_cc);
`endif
        gen_vector();
        run_vector(NO_GAP, 0, 1'b0, 0, 1 + N + COMPUTE + N);

        // Asynchronous reset in the middle of compute
        gen_vector();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_vector(NO_GAP, 0);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        check("async_rst_lam_reset", lam_reset, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_lam_mean", lam_mean, 0);
        check("async_rst_z_valid", z_valid, 0);
`ifdef LAMBDA_SCHED_PERF_EN
        check("async_rst_cycle_count", cycle_count, 0);
`endif
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Randomized vectors with gaps, backpressure and ignored start/in_valid noise
        for (int r = 0; r < 6; r++) begin
            gen_vector();
            run_vector($urandom_range(0, N), $urandom_range(1, 4), 1'b1, r % 3, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lambda_scheduler.md
Name: lambda_scheduler

Overview:
- Sequences one shared lambda_layer_v2 instance over a latent vector of N_LATENT (mean, var) pairs coming from the encoder.
- Buffers the pairs, then per element: pulses the lambda layer reset, holds its inputs for a fixed LAT-cycle settling window, and captures lambda_out.
- Streams the N results to the decoder side over a valid/ready interface.
- Sits between the encoder output stage and the decoder input stage.

Parameters:
- DW, 16, data width of mean, var and lambda output.
- N_LATENT, 4, elements per latent vector (>=1).
- LAT, 8, cycles lam_reset is held low before capture (>=1).
- IW, $clog2(N_LATENT) with a minimum of 1, width of index counters and z_index.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a vector; sampled only in IDLE
- abort  in  1  synchronous return to IDLE from any state; no done pulse
- in_valid  in  1  encoder pair valid
- in_ready  out  1  scheduler accepts a pair
- in_mean  in  DW  encoder mean
- in_var  in  DW  encoder variance
- lam_reset  out  1  active-high reset to the lambda layer
- lam_mean  out  DW  lambda layer mean input
- lam_var  out  DW  lambda layer vare input
- lam_out  in  DW  lambda layer output
- z_valid  out  1  result valid
- z_ready  in  1  downstream accepts result
- z_data  out  DW  result value
- z_index  out  IW  element index of z_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- All outputs are registered.
- Reset values (reset=0): state IDLE, lam_reset=1, lam_mean=lam_var=0, in_ready=0, z_valid=0, z_data=0, z_index=0, busy=0, done=0, all counters 0, buffers 0.
- State IDLE: start=1 -> LOAD; load index k=0.
- State LOAD: in_ready=1; each in_valid&in_ready writes buf[k]={in_mean,in_var} and increments k.
  - The handshake with k=N_LATENT-1 -> RST, with k=0, in_ready=0 next cycle.
- State RST (1 cycle): lam_reset=1, lam_mean/lam_var=buf[k]; wait counter loaded with LAT-1 -> WAIT.
- State WAIT: lam_reset=0, lam_mean/lam_var held; counter decrements each cycle.
  - On the cycle the counter is 0: res[k]=lam_out.
  - If k=N_LATENT-1 -> OUT with j=0; else k++ -> RST.
- State OUT: z_valid=1, z_data=res[j], z_index=j.
  - Each z_valid&z_ready advances j; data and index are held stable while z_ready=0.
  - The handshake at j=N_LATENT-1 -> IDLE, z_valid=0, done=1 for exactly one cycle.
- lam_reset=1 in every state except WAIT.
- Compute latency: N_LATENT*(1+LAT) cycles from the cycle after the last load handshake to entry into OUT. With the defaults this is 36 cycles.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- abort has priority over every transition:
  - next state IDLE, lam_reset=1, in_ready=0, z_valid=0, done=0.
  - Buffers are kept but are not valid.
- start and abort high in the same cycle in IDLE: abort wins, stays IDLE.
- Asynchronous reset mid-operation: immediate return to the reset values; no partial output is emitted.
- N_LATENT=1: LOAD accepts one pair and goes directly to RST. LAT=1: WAIT lasts one cycle.

Optional Feature:
- Macro: LAMBDA_SCHED_PERF_EN.
- Defined:
  - Adds output port cycle_count, out, 16 bits.
  - Cleared in the cycle start is accepted, then increments every cycle while busy=1, saturating at 16'hFFFF.
  - Frozen when done pulses; cleared by reset.
  - abort freezes it.
- Undefined: the port and its logic do not exist.

Test Plan:
- Lambda stub for all scenarios: lam_out = 0 while lam_reset=1, else lam_mean+lam_var (mod 2^16) two cycles after lam_reset falls.
- Scenario 1, reset: reset=0 for 3 cycles -> lam_reset=1, z_valid=0, busy=0, in_ready=0.
- Scenario 2, nominal run:
  - Stimulus: start, then pairs (16'h0010,16'h0001), (16'h0100,16'h0002), (16'hFFFF,16'h0002), (16'h0000,16'h0000) with in_valid continuous, z_ready=1.
  - Response: z_data 16'h0011, 16'h0102, 16'h0001, 16'h0000 with z_index 0..3.
  - First z_valid 36 cycles after the last load handshake; one done pulse.
- Scenario 3, backpressure: same run with z_ready toggling 1,0,0,1,... -> z_data/z_index stable while z_ready=0; all 4 results in order; done only after index 3 handshake.
- Scenario 4, gapped input: in_valid low for 5 cycles between pairs 1 and 2 -> no transition to RST until the 4th pair; lam_reset stays 1 throughout LOAD.
- Scenario 5, abort: abort asserted in WAIT of element 2 -> next cycle state IDLE, lam_reset=1, busy=0, no z_valid, no done; a following start runs normally.
- Scenario 6, LAMBDA_SCHED_PERF_EN:
  - Scenario 2 run with z_ready=1 -> cycle_count equals the cycles from start accept to done and then holds.
  - Value for that run: 1 IDLE cycle + 4 load + 36 compute + 4 output = 45.
